// File: rtl/pc_redirect_arb_if.sv
// PFU PC write port between the redirect arbiter
// and the prefetch unit.
interface pc_redirect_arb_if #(
  parameter int C_XLEN = 32
);
  logic              pfu_pc_ready_i;
  logic              pfu_pc_wr_o;
  logic [C_XLEN-1:0] pfu_pc_o;

  modport master (
    input  pfu_pc_ready_i,
    output pfu_pc_wr_o,
    output pfu_pc_o
  );

  modport slave (
    output pfu_pc_ready_i,
    input  pfu_pc_wr_o,
    input  pfu_pc_o
  );
endinterface

// File: rtl/pc_redirect_arb.sv
// PC redirect arbiter: trap > irq > ret > jump onto one
// PFU write port. Optional macro: PC_REDIR_VECTORED_EN.
module pc_redirect_arb #(
  parameter int C_XLEN    = 32,
  parameter int C_CAUSE_W = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clk_en_i,
  input  logic                 trap_req_i,
  input  logic                 irq_req_i,
  input  logic [C_CAUSE_W-1:0] irq_cause_i,
  input  logic [C_XLEN-1:0]    trap_base_i,
  input  logic                 ret_req_i,
  input  logic [C_XLEN-1:0]    ret_addr_i,
  input  logic                 jump_req_i,
  input  logic [C_XLEN-1:0]    jump_addr_i,
  pc_redirect_arb_if.master    pfu,
  output logic                 trap_ack_o,
  output logic                 irq_ack_o,
  output logic                 ret_ack_o,
  output logic                 jump_ack_o,
  output logic                 flush_o,
  output logic                 busy_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  localparam logic [1:0] P_TRAP = 2'd3;
  localparam logic [1:0] P_IRQ  = 2'd2;
  localparam logic [1:0] P_RET  = 2'd1;
  localparam logic [1:0] P_JUMP = 2'd0;

  logic [0:0]        state_q;
  logic [C_XLEN-1:0] hold_addr_q;
  logic [1:0]        hold_pri_q;

  logic [C_XLEN-1:0] base_addr;
  logic [C_XLEN-1:0] irq_addr;
  logic              cand_vld;
  logic [1:0]        cand_pri;
  logic [C_XLEN-1:0] cand_addr;
  logic              accept;
  logic              bypass;
  logic              held_wr;

  assign base_addr = {trap_base_i[C_XLEN-1:2], 2'b00};

`ifdef PC_REDIR_VECTORED_EN
  logic [C_XLEN-1:0] cause_off;
  assign cause_off = C_XLEN'(irq_cause_i) << 2;
  assign irq_addr  = (trap_base_i[1:0] == 2'b01) ?
                     base_addr + cause_off : base_addr;
`else
  logic unused_vec;
  assign unused_vec = ^{irq_cause_i, trap_base_i[1:0]};
  assign irq_addr   = base_addr;
`endif

  // Pick the highest-priority request this cycle.
  always_comb begin
    cand_vld  = 1'b1;
    cand_pri  = P_JUMP;
    cand_addr = jump_addr_i;
    priority case (1'b1)
      trap_req_i: begin
        cand_pri  = P_TRAP;
        cand_addr = base_addr;
      end
      irq_req_i: begin
        cand_pri  = P_IRQ;
        cand_addr = irq_addr;
      end
      ret_req_i: begin
        cand_pri  = P_RET;
        cand_addr = ret_addr_i;
      end
      jump_req_i: begin
        cand_pri  = P_JUMP;
        cand_addr = jump_addr_i;
      end
      default: cand_vld = 1'b0;
    endcase
  end

  // Accept, bypass and write-strobe decisions.
  always_comb begin
    accept  = 1'b0;
    held_wr = 1'b0;
    if (!reset_i && clk_en_i && cand_vld) begin
      if (state_q == S_IDLE)
        accept = 1'b1;
      else
        accept = (cand_pri > hold_pri_q);
    end
    bypass = accept & pfu.pfu_pc_ready_i;
    if (!reset_i && clk_en_i &&
        state_q == S_HOLD && !accept)
      held_wr = pfu.pfu_pc_ready_i;
  end

  assign pfu.pfu_pc_wr_o = bypass | held_wr;
  assign pfu.pfu_pc_o    = reset_i ? '0 :
                           bypass  ? cand_addr :
                                     hold_addr_q;

  assign trap_ack_o = accept & (cand_pri == P_TRAP);
  assign irq_ack_o  = accept & (cand_pri == P_IRQ);
  assign ret_ack_o  = accept & (cand_pri == P_RET);
  assign jump_ack_o = accept & (cand_pri == P_JUMP);
  assign flush_o    = accept;
  assign busy_o     = (state_q == S_HOLD);

  // Park unaccepted redirects; release on PFU ready.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      hold_addr_q <= '0;
      hold_pri_q  <= '0;
    end else if (clk_en_i) begin
      if (accept && !pfu.pfu_pc_ready_i) begin
        state_q     <= S_HOLD;
        hold_addr_q <= cand_addr;
        hold_pri_q  <= cand_pri;
      end else if (pfu.pfu_pc_ready_i) begin
        state_q <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_pc_redirect_arb.sv
// Directed bench for pc_redirect_arb.
// Expected values are hand-computed per step.
module tb_pc_redirect_arb;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        clk_en_i;
  logic        trap_req_i;
  logic        irq_req_i;
  logic [3:0]  irq_cause_i;
  logic [31:0] trap_base_i;
  logic        ret_req_i;
  logic [31:0] ret_addr_i;
  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        trap_ack_o;
  logic        irq_ack_o;
  logic        ret_ack_o;
  logic        jump_ack_o;
  logic        flush_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] vec_exp;

  pc_redirect_arb_if #(.C_XLEN(32)) pfu_if ();

  pc_redirect_arb #(
    .C_XLEN   (32),
    .C_CAUSE_W(4)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clk_en_i   (clk_en_i),
    .trap_req_i (trap_req_i),
    .irq_req_i  (irq_req_i),
    .irq_cause_i(irq_cause_i),
    .trap_base_i(trap_base_i),
    .ret_req_i  (ret_req_i),
    .ret_addr_i (ret_addr_i),
    .jump_req_i (jump_req_i),
    .jump_addr_i(jump_addr_i),
    .pfu        (pfu_if.master),
    .trap_ack_o (trap_ack_o),
    .irq_ack_o  (irq_ack_o),
    .ret_ack_o  (ret_ack_o),
    .jump_ack_o (jump_ack_o),
    .flush_o    (flush_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    trap_req_i = 1'b0;
    irq_req_i  = 1'b0;
    ret_req_i  = 1'b0;
    jump_req_i = 1'b0;
  endtask

  initial begin
    reset_i     = 1'b1;
    clk_en_i    = 1'b1;
    irq_cause_i = 4'd0;
    trap_base_i = 32'h0;
    ret_addr_i  = 32'h0;
    jump_addr_i = 32'h0;
    idle_in();
    pfu_if.pfu_pc_ready_i = 1'b1;
`ifdef PC_REDIR_VECTORED_EN
    vec_exp = 32'h0000_4014;
`else
    vec_exp = 32'h0000_4000;
`endif

    // strobes stay low under reset even with a request
    jump_req_i  = 1'b1;
    jump_addr_i = 32'h0000_0abc;
    #2;
    chk("rst_wr", 32'(pfu_if.pfu_pc_wr_o), 32'd0);
    chk("rst_ack", 32'(jump_ack_o), 32'd0);
    chk("rst_flush", 32'(flush_o), 32'd0);
    chk("rst_pc", pfu_if.pfu_pc_o, 32'h0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    idle_in();
    tick();
    reset_i = 1'b0;
    tick();

    // idle bypass
    jump_req_i  = 1'b1;
    jump_addr_i = 32'h0000_1234;
    #1;
    chk("byp_wr", 32'(pfu_if.pfu_pc_wr_o), 32'd1);
    chk("byp_pc", pfu_if.pfu_pc_o, 32'h0000_1234);
    chk("byp_ack", 32'(jump_ack_o), 32'd1);
    chk("byp_flush", 32'(flush_o), 32'd1);
    tick();
    idle_in();
    chk("byp_busy", 32'(busy_o), 32'd0);

    // park, drop equal priority, release
    pfu_if.pfu_pc_ready_i = 1'b0;
    jump_req_i  = 1'b1;
    jump_addr_i = 32'h0000_0100;
    #1;
    chk("park_wr", 32'(pfu_if.pfu_pc_wr_o), 32'd0);
    chk("park_ack", 32'(jump_ack_o), 32'd1);
    chk("park_flush", 32'(flush_o), 32'd1);
    tick();
    chk("park_busy", 32'(busy_o), 32'd1);
    jump_addr_i = 32'h0000_0200;
    #1;
    chk("drop_ack", 32'(jump_ack_o), 32'd0);
    chk("drop_flush", 32'(flush_o), 32'd0);
    chk("drop_wr", 32'(pfu_if.pfu_pc_wr_o), 32'd0);
    chk("drop_pc", pfu_if.pfu_pc_o, 32'h0000_0100);
    tick();
    chk("drop_busy", 32'(busy_o), 32'd1);
    idle_in();
    pfu_if.pfu_pc_ready_i = 1'b1;
    #1;
    chk("rel_wr", 32'(pfu_if.pfu_pc_wr_o), 32'd1);
    chk("rel_pc", pfu_if.pfu_pc_o, 32'h0000_0100);
    tick();
    chk("rel_busy", 32'(busy_o), 32'd0);
    #1;
    chk("rel_nowr", 32'(pfu_if.pfu_pc_wr_o), 32'd0);

    // trap preempts held jump with ready
    pfu_if.pfu_pc_ready_i = 1'b0;
    jump_req_i  = 1'b1;
    jump_addr_i = 32'h0000_0100;
    tick();
    chk("pre_busy", 32'(busy_o), 32'd1);
    idle_in();
    trap_req_i  = 1'b1;
    trap_base_i = 32'h8000_0003;
    pfu_if.pfu_pc_ready_i = 1'b1;
    #1;
    chk("pre_wr", 32'(pfu_if.pfu_pc_wr_o), 32'd1);
    chk("pre_pc", pfu_if.pfu_pc_o, 32'h8000_0000);
    chk("pre_tack", 32'(trap_ack_o), 32'd1);
    chk("pre_flush", 32'(flush_o), 32'd1);
    tick();
    idle_in();
    chk("pre_busy2", 32'(busy_o), 32'd0);
    #1;
    chk("pre_nowr", 32'(pfu_if.pfu_pc_wr_o), 32'd0);

    // simultaneous trap, irq, jump
    trap_req_i  = 1'b1;
    irq_req_i   = 1'b1;
    jump_req_i  = 1'b1;
    jump_addr_i = 32'h0000_0500;
    #1;
    chk("sim_tack", 32'(trap_ack_o), 32'd1);
    chk("sim_iack", 32'(irq_ack_o), 32'd0);
    chk("sim_jack", 32'(jump_ack_o), 32'd0);
    chk("sim_pc", pfu_if.pfu_pc_o, 32'h8000_0000);
    tick();
    idle_in();

    // irq target, vectored or direct
    irq_req_i   = 1'b1;
    irq_cause_i = 4'd5;
    trap_base_i = 32'h0000_4001;
    #1;
    chk("irq_ack", 32'(irq_ack_o), 32'd1);
    chk("irq_pc", pfu_if.pfu_pc_o, vec_exp);
    tick();
    idle_in();

    // irq replaces held ret without ready
    pfu_if.pfu_pc_ready_i = 1'b0;
    ret_req_i  = 1'b1;
    ret_addr_i = 32'h0000_0300;
    #1;
    chk("ret_ack", 32'(ret_ack_o), 32'd1);
    tick();
    idle_in();
    irq_req_i   = 1'b1;
    trap_base_i = 32'h0000_4000;
    #1;
    chk("rep_ack", 32'(irq_ack_o), 32'd1);
    chk("rep_wr", 32'(pfu_if.pfu_pc_wr_o), 32'd0);
    chk("rep_pc", pfu_if.pfu_pc_o, 32'h0000_0300);
    tick();
    idle_in();
    pfu_if.pfu_pc_ready_i = 1'b1;
    #1;
    chk("rep_wr2", 32'(pfu_if.pfu_pc_wr_o), 32'd1);
    chk("rep_pc2", pfu_if.pfu_pc_o, 32'h0000_4000);
    tick();

    // reset in hold
    pfu_if.pfu_pc_ready_i = 1'b0;
    jump_req_i  = 1'b1;
    jump_addr_i = 32'h0000_0100;
    tick();
    idle_in();
    chk("hrst_busy0", 32'(busy_o), 32'd1);
    reset_i = 1'b1;
    #1;
    chk("hrst_busy", 32'(busy_o), 32'd0);
    chk("hrst_pc", pfu_if.pfu_pc_o, 32'h0);
    tick();
    reset_i = 1'b0;
    pfu_if.pfu_pc_ready_i = 1'b1;
    #1;
    chk("hrst_nowr", 32'(pfu_if.pfu_pc_wr_o), 32'd0);
    tick();

    // clock enable low
    clk_en_i    = 1'b0;
    jump_req_i  = 1'b1;
    jump_addr_i = 32'h0000_0700;
    #1;
    chk("cen_ack", 32'(jump_ack_o), 32'd0);
    chk("cen_wr", 32'(pfu_if.pfu_pc_wr_o), 32'd0);
    chk("cen_flush", 32'(flush_o), 32'd0);
    tick();
    chk("cen_busy", 32'(busy_o), 32'd0);
    idle_in();
    clk_en_i = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
